// File: rtl/videotex_pixel_serializer_if.sv
// videotex_pixel_serializer_if: cell slice, attribute and colour-index bundle between
// the character generator (master) and the pixel serializer (slave).
interface videotex_pixel_serializer_if #(
    parameter int COLOR_WIDTH = 3
);
    logic                   load;
    logic [7:0]             row_pixels;
    logic [COLOR_WIDTH-1:0] fg_color;
    logic [COLOR_WIDTH-1:0] bg_color;
    logic                   flash;
    logic                   conceal;
    logic                   reveal;
    logic                   cursor;
    logic                   video_active;
    logic                   frame_start;
    logic [COLOR_WIDTH-1:0] pixel_color;
    logic                   flash_phase;
    logic                   underrun;
    modport master (
        output load, row_pixels, fg_color, bg_color, flash, conceal, reveal, cursor,
               video_active, frame_start,
        input  pixel_color, flash_phase, underrun
    );
    modport slave (
        input  load, row_pixels, fg_color, bg_color, flash, conceal, reveal, cursor,
               video_active, frame_start,
        output pixel_color, flash_phase, underrun
    );
endinterface

// File: rtl/videotex_pixel_serializer.sv
// videotex_pixel_serializer: shifts 8-pixel cell slices out MSB first with flash/conceal/blanking.
// Optional cursor swap enabled by defining VIDEOTEX_CURSOR_EN.
module videotex_pixel_serializer #(
    parameter int COLOR_WIDTH  = 3,
    parameter int FLASH_FRAMES = 32
) (
    input logic                          clk,
    input logic                          reset,
    videotex_pixel_serializer_if.slave   bus
);
    logic [7:0]             sh;
    logic [2:0]             bit_count;
    logic                   valid;
    logic [COLOR_WIDTH-1:0] fg_h, bg_h;
    logic                   fl_h, co_h;
    logic [7:0]             frame_cnt;
`ifdef VIDEOTEX_CURSOR_EN
    logic                   cu_h;
`endif
    logic                   p, fl, co, slot, fg_vis, swap, frame_last;
    logic [COLOR_WIDTH-1:0] fg, bg, color, next_pixel;
    // The pixel registered at this edge is the new slice MSB on a load, otherwise
    // the bit that the shift is about to move into the MSB position.
    always_comb begin
        p          = bus.load ? bus.row_pixels[7] : sh[6];
        fg         = bus.load ? bus.fg_color : fg_h;
        bg         = bus.load ? bus.bg_color : bg_h;
        fl         = bus.load ? bus.flash : fl_h;
        co         = bus.load ? bus.conceal : co_h;
        slot       = bus.load || (valid && bit_count != 3'd7);
        fg_vis     = p && !(fl && !bus.flash_phase) && !(co && !bus.reveal);
`ifdef VIDEOTEX_CURSOR_EN
        swap       = (bus.load ? bus.cursor : cu_h) && bus.flash_phase;
`else
        swap       = 1'b0;
`endif
        color      = (fg_vis ^ swap) ? fg : bg;
        next_pixel = !bus.video_active ? '0 : slot ? color : bg_h;
        frame_last = frame_cnt == 8'(FLASH_FRAMES - 1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sh              <= '0;
            bit_count       <= '0;
            valid           <= 1'b0;
            fg_h            <= '0;
            bg_h            <= '0;
            fl_h            <= 1'b0;
            co_h            <= 1'b0;
`ifdef VIDEOTEX_CURSOR_EN
            cu_h            <= 1'b0;
`endif
            frame_cnt       <= '0;
            bus.pixel_color <= '0;
            bus.flash_phase <= 1'b1;
            bus.underrun    <= 1'b0;
        end else begin
            if (bus.load) begin
                sh        <= bus.row_pixels;
                bit_count <= '0;
                valid     <= 1'b1;
                fg_h      <= bus.fg_color;
                bg_h      <= bus.bg_color;
                fl_h      <= bus.flash;
                co_h      <= bus.conceal;
`ifdef VIDEOTEX_CURSOR_EN
                cu_h      <= bus.cursor;
`endif
            end else if (valid) begin
                sh        <= {sh[6:0], 1'b0};
                bit_count <= bit_count + 3'd1;
                valid     <= bit_count != 3'd7;
            end
            bus.pixel_color <= next_pixel;
            bus.underrun    <= (bus.video_active && !slot) || (bus.underrun && !bus.frame_start);
            if (bus.frame_start) begin
                frame_cnt       <= frame_last ? 8'd0 : frame_cnt + 8'd1;
                bus.flash_phase <= bus.flash_phase ^ frame_last;
            end
        end
    end
endmodule

// File: tb/tb_videotex_pixel_serializer.sv
// tb_videotex_pixel_serializer: directed and randomized checks of the pixel serializer
// against a queue-based reference model (FLASH_FRAMES = 4).
module tb_videotex_pixel_serializer;
    localparam int FF = 4;
`ifdef VIDEOTEX_CURSOR_EN
    localparam bit CUR = 1'b1;
`else
    localparam bit CUR = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    videotex_pixel_serializer_if #(.COLOR_WIDTH(3)) b();
    videotex_pixel_serializer #(.COLOR_WIDTH(3), .FLASH_FRAMES(FF)) dut (
        .clk(clk), .reset(reset), .bus(b)
    );
    always #5 clk = ~clk;
    // Reference model: a slice is a queue of pending pixels; each clock consumes one.
    logic       mq[$];
    logic [2:0] m_fg, m_bg, m_pix;
    logic       m_fl, m_co, m_cu, m_phase, m_und;
    int         m_frames;
    logic [2:0] exp_basic  [8] = '{3'd7, 3'd1, 3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 3'd7};
    logic [2:0] exp_cur_on [8] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd2, 3'd2, 3'd2, 3'd2};
    logic [2:0] exp_cur_off[8] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5};
    task automatic model_reset();
        mq.delete();
        m_fg = 0; m_bg = 0; m_pix = 0; m_fl = 0; m_co = 0; m_cu = 0;
        m_phase = 1; m_und = 0; m_frames = 0;
    endtask
    task automatic model_step();
        logic has, p, vis, sw;
        if (b.load) begin
            mq.delete();
            for (int i = 7; i >= 0; i--) mq.push_back(b.row_pixels[i]);
            m_fg = b.fg_color; m_bg = b.bg_color; m_fl = b.flash; m_co = b.conceal; m_cu = b.cursor;
        end
        has = mq.size() > 0;
        p   = has ? mq.pop_front() : 1'b0;
        vis = p && !(m_fl && !m_phase) && !(m_co && !b.reveal);
        sw  = CUR && m_cu && m_phase;
        m_pix = !b.video_active ? 3'd0 : !has ? m_bg : (vis != sw) ? m_fg : m_bg;
        m_und = (b.video_active && !has) || (m_und && !b.frame_start);
        if (b.frame_start) begin
            m_frames++;
            if (m_frames == FF) begin
                m_frames = 0;
                m_phase  = !m_phase;
            end
        end
    endtask
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_cell(input logic [7:0] row, input logic [2:0] fg, input logic [2:0] bg,
                            input logic fl, input logic co, input logic cu);
        b.row_pixels = row; b.fg_color = fg; b.bg_color = bg;
        b.flash = fl; b.conceal = co; b.cursor = cu;
    endtask
    task automatic load_tick();
        b.load = 1'b1;
        tick();
        b.load = 1'b0;
    endtask
    task automatic frame_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            b.frame_start = 1'b1;
            tick();
            b.frame_start = 1'b0;
            tick();
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        b.load = 0; b.reveal = 0; b.video_active = 0; b.frame_start = 0;
        set_cell(8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask
    task automatic test_reset();
        do_reset();
        n_tests++;
        if (b.pixel_color !== 3'd0 || b.underrun !== 1'b0 || b.flash_phase !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: pix=%0d und=%0b phase=%0b, want 0/0/1",
                     b.pixel_color, b.underrun, b.flash_phase);
        end
    endtask
    task automatic test_basic();
        b.video_active = 1'b1;
        set_cell(8'b1010_0001, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) load_tick(); else tick();
            n_tests++;
            if (b.pixel_color !== exp_basic[k] || b.underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL basic[%0d]: pix=%0d und=%0b, want %0d/0",
                         k, b.pixel_color, b.underrun, exp_basic[k]);
            end
        end
    endtask
    task automatic test_back_to_back();
        for (int c = 0; c < 3; c++) begin
            set_cell(8'($urandom), 3'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 8; k++) begin
                if (k == 0) load_tick(); else tick();
                n_tests++;
                if (b.pixel_color !== m_pix || b.underrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b[%0d.%0d]: pix=%0d und=%0b, want %0d/0",
                             c, k, b.pixel_color, b.underrun, m_pix);
                end
            end
        end
        set_cell(8'h00, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0);
        load_tick();
        repeat (3) tick();
        set_cell(8'h80, 3'd6, 3'd2, 1'b0, 1'b0, 1'b0);
        load_tick();
        n_tests++;
        if (b.pixel_color !== 3'd6 || b.underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL early_load: pix=%0d und=%0b, want 6/0", b.pixel_color, b.underrun);
        end
        for (int k = 1; k < 8; k++) begin
            tick();
            n_tests++;
            if (b.pixel_color !== 3'd2) begin
                n_fail++;
                $display("FAIL early_tail[%0d]: pix=%0d, want 2", k, b.pixel_color);
            end
        end
    endtask
    task automatic test_underrun();
        tick();
        n_tests++;
        if (b.pixel_color !== 3'd2 || b.underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_set: pix=%0d und=%0b, want 2/1", b.pixel_color, b.underrun);
        end
        b.video_active = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (b.underrun !== 1'b1 || b.pixel_color !== 3'd0) begin
            n_fail++;
            $display("FAIL underrun_hold: und=%0b pix=%0d, want 1/0", b.underrun, b.pixel_color);
        end
        frame_pulses(1);
        n_tests++;
        if (b.underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_clear: und=%0b, want 0", b.underrun);
        end
        b.video_active = 1'b1;
        b.frame_start  = 1'b1;
        tick();
        b.frame_start  = 1'b0;
        b.video_active = 1'b0;
        n_tests++;
        if (b.underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_set_wins: und=%0b, want 1", b.underrun);
        end
        frame_pulses(1);
    endtask
    task automatic test_flash();
        do_reset();
        frame_pulses(4);
        n_tests++;
        if (b.flash_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL flash_phase_off: phase=%0b, want 0", b.flash_phase);
        end
        b.video_active = 1'b1;
        set_cell(8'hFF, 3'd3, 3'd4, 1'b1, 1'b0, 1'b0);
        load_tick();
        n_tests++;
        if (b.pixel_color !== 3'd4) begin
            n_fail++;
            $display("FAIL flash_bg: pix=%0d, want 4", b.pixel_color);
        end
        b.video_active = 1'b0;
        repeat (7) tick();
        frame_pulses(4);
        n_tests++;
        if (b.flash_phase !== 1'b1) begin
            n_fail++;
            $display("FAIL flash_phase_on: phase=%0b, want 1", b.flash_phase);
        end
        b.video_active = 1'b1;
        load_tick();
        n_tests++;
        if (b.pixel_color !== 3'd3) begin
            n_fail++;
            $display("FAIL flash_fg: pix=%0d, want 3", b.pixel_color);
        end
        repeat (7) tick();
    endtask
    task automatic test_conceal();
        b.video_active = 1'b1;
        b.reveal = 1'b0;
        set_cell(8'hFF, 3'd5, 3'd2, 1'b0, 1'b1, 1'b0);
        load_tick();
        tick();
        n_tests++;
        if (b.pixel_color !== 3'd2) begin
            n_fail++;
            $display("FAIL conceal: pix=%0d, want 2", b.pixel_color);
        end
        b.reveal = 1'b1;
        tick();
        n_tests++;
        if (b.pixel_color !== 3'd5) begin
            n_fail++;
            $display("FAIL reveal: pix=%0d, want 5", b.pixel_color);
        end
        b.video_active = 1'b0;
        tick();
        n_tests++;
        if (b.pixel_color !== 3'd0) begin
            n_fail++;
            $display("FAIL blank: pix=%0d, want 0", b.pixel_color);
        end
        b.reveal = 1'b0;
        repeat (4) tick();
    endtask
    task automatic test_cursor();
        do_reset();
        b.video_active = 1'b1;
        set_cell(8'hF0, 3'd2, 3'd5, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) load_tick(); else tick();
            n_tests++;
            if (b.pixel_color !== (CUR ? exp_cur_on[k] : exp_cur_off[k])) begin
                n_fail++;
                $display("FAIL cursor_on[%0d]: pix=%0d, want %0d",
                         k, b.pixel_color, CUR ? exp_cur_on[k] : exp_cur_off[k]);
            end
        end
        b.video_active = 1'b0;
        frame_pulses(4);
        b.video_active = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) load_tick(); else tick();
            n_tests++;
            if (b.pixel_color !== exp_cur_off[k]) begin
                n_fail++;
                $display("FAIL cursor_off[%0d]: pix=%0d, want %0d", k, b.pixel_color, exp_cur_off[k]);
            end
        end
    endtask
    task automatic test_random();
        int gap = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_cell(8'($urandom), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            b.video_active = $urandom_range(0, 9) != 0;
            b.reveal       = $urandom_range(0, 7) == 0;
            b.frame_start  = $urandom_range(0, 19) == 0;
            b.load         = gap == 0;
            gap            = (gap == 0) ? $urandom_range(1, 10) : gap - 1;
            tick();
            b.load = 1'b0;
            n_tests++;
            if (b.pixel_color !== m_pix || b.underrun !== m_und || b.flash_phase !== m_phase) begin
                n_fail++;
                $display("FAIL random[%0d]: pix=%0d und=%0b phase=%0b, want %0d/%0b/%0b",
                         i, b.pixel_color, b.underrun, b.flash_phase, m_pix, m_und, m_phase);
            end
        end
        b.frame_start = 1'b0;
    endtask
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_flash();
        test_conceal();
        test_cursor();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
